// File: rtl/map_sel_pkg.sv
// -----------------------------------------------------------------------------
// map_sel_pkg
// Shared definitions for the runtime mapper-select sequencer:
//   - map_state_t   : sequencer states (IDLE, SYNC, RESET, RELEASE, DONE)
//   - MAP_IDX_W     : width of a mapper index
//   - MAP_IDX_NOM   : index of the "nom" (no-op) mapper selected after reset
//   - MAP_IDX_LIST  : mapper indices the hub actually implements
//   - cnt_w()       : counter width helper (never returns 0)
//   - idx_supported(): membership test against MAP_IDX_LIST
// -----------------------------------------------------------------------------
package map_sel_pkg;

    localparam int MAP_IDX_W = 8;
    localparam logic [MAP_IDX_W-1:0] MAP_IDX_NOM = '0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        RESET   = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } map_state_t;

    localparam int MAP_IDX_NUM = 31;
    localparam logic [MAP_IDX_W-1:0] MAP_IDX_LIST [MAP_IDX_NUM] = '{
        8'd0,   8'd15,  8'd28,  8'd40,  8'd41,  8'd42,  8'd57,  8'd58,
        8'd61,  8'd91,  8'd99,  8'd101, 8'd107, 8'd112, 8'd164, 8'd168,
        8'd178, 8'd188, 8'd193, 8'd200, 8'd201, 8'd202, 8'd203, 8'd212,
        8'd227, 8'd231, 8'd234, 8'd240, 8'd241, 8'd242, 8'd246
    };

    // $clog2 of the count, but at least one bit so tiny parameters still
    // give a legal vector.
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic logic idx_supported(input logic [MAP_IDX_W-1:0] idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < MAP_IDX_NUM; i++) begin
            if (MAP_IDX_LIST[i] == idx) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/map_idx_lut.sv
// -----------------------------------------------------------------------------
// map_idx_lut
// Combinational check of a requested mapper index against the set of mappers
// the hub implements.
// Ports:
//   idx       in  8  requested mapper index
//   supported out 1  high when idx is in MAP_IDX_LIST
// -----------------------------------------------------------------------------
module map_idx_lut
    import map_sel_pkg::*;
(
    input  logic [MAP_IDX_W-1:0] idx,
    output logic                 supported
);

    always_comb begin
        supported = idx_supported(idx);
    end

endmodule

// File: rtl/map_sel_ctrl.sv
// -----------------------------------------------------------------------------
// map_sel_ctrl
// Runtime mapper-select sequencer between the host config interface and the
// mapper hub select. A request is accepted in IDLE, the sequencer waits for a
// quiet CPU bus (or a timeout), holds the mapper in reset while committing the
// new index, releases reset, waits for the mapper to settle and acknowledges.
// The hub select therefore only changes while the mapper is held in reset,
// never in the middle of a CPU cycle.
//
// Build option: define MAP_IDX_CHECK_EN to reject unsupported indices with an
// err pulse. Without it every index is accepted and err is tied low.
//
// Ports:
//   clk        in   1  system clock
//   rst        in   1  synchronous active-high reset
//   m2         in   1  CPU phi2, already synchronised to clk
//   req        in   1  host request (level), sampled only in IDLE
//   req_idx    in   8  requested mapper index, captured with req
//   map_idx    out  8  committed mapper index to hub select
//   map_rst    out  1  mapper logic reset
//   busy       out  1  high in every state except IDLE
//   ack        out  1  one-cycle completion pulse
//   err        out  1  one-cycle rejected-request pulse (MAP_IDX_CHECK_EN only)
//   forced     out  1  sticky: last switch was forced by the quiet timeout
//   state_dbg  out  3  current sequencer state (map_state_t encoding)
//
// Handshake: the host raises req with req_idx stable; the request is taken on
// the first clk edge that sees req=1 while busy=0 (IDLE). req is ignored while
// busy=1. Completion is the single-cycle ack (or err when the index is
// rejected); the host must have dropped req by the cycle after that pulse,
// otherwise it is taken as a new request.
// -----------------------------------------------------------------------------
module map_sel_ctrl
    import map_sel_pkg::*;
#(
    parameter int QUIET_CYC  = 8,
    parameter int QUIET_TO   = 4096,
    parameter int RST_CYC    = 16,
    parameter int SETTLE_CYC = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m2,
    input  logic                 req,
    input  logic [MAP_IDX_W-1:0] req_idx,
    output logic [MAP_IDX_W-1:0] map_idx,
    output logic                 map_rst,
    output logic                 busy,
    output logic                 ack,
    output logic                 err,
    output logic                 forced,
    output logic [2:0]           state_dbg
);

    localparam int Q_W = cnt_w(QUIET_CYC);
    localparam int T_W = cnt_w(QUIET_TO);
    localparam int R_W = cnt_w(RST_CYC);
    localparam int S_W = cnt_w(SETTLE_CYC);

    localparam logic [Q_W-1:0] Q_LAST = Q_W'(QUIET_CYC - 1);
    localparam logic [T_W-1:0] T_LAST = T_W'(QUIET_TO - 1);
    localparam logic [R_W-1:0] R_LAST = R_W'(RST_CYC - 1);
    localparam logic [S_W-1:0] S_LAST = S_W'(SETTLE_CYC - 1);

    map_state_t           state;
    map_state_t           state_nxt;
    logic [Q_W-1:0]       q_cnt;
    logic [T_W-1:0]       t_cnt;
    logic [R_W-1:0]       r_cnt;
    logic [S_W-1:0]       s_cnt;
    logic [MAP_IDX_W-1:0] pend_idx;
    logic                 por_q;
    logic                 req_ok;
    logic                 accept;
    logic                 quiet_hit;
    logic                 to_hit;

`ifdef MAP_IDX_CHECK_EN
    logic idx_ok;
    logic err_q;

    map_idx_lut u_map_idx_lut (
        .idx       (req_idx),
        .supported (idx_ok)
    );

    assign req_ok = idx_ok;
    assign err    = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && req && !idx_ok;
        end
    end
`else
    assign req_ok = 1'b1;
    assign err    = 1'b0;
`endif

    assign accept = (state == IDLE) && req && req_ok;

    // Quiet window: QUIET_CYC consecutive low m2 samples, the current one
    // included. q_cnt holds the number of lows already seen before this cycle.
    assign quiet_hit = (state == SYNC) && !m2 && (q_cnt == Q_LAST);
    assign to_hit    = (state == SYNC) && (t_cnt == T_LAST);

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)                state_nxt = SYNC;
            SYNC:    if (quiet_hit || to_hit)   state_nxt = RESET;
            RESET:   if (r_cnt == R_LAST)       state_nxt = RELEASE;
            RELEASE: if (s_cnt == S_LAST)       state_nxt = DONE;
            DONE:                               state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        busy      = (state != IDLE);
        ack       = (state == DONE);
        // por_q keeps the mapper in reset for the cycle right after rst.
        map_rst   = por_q || (state == RESET);
        state_dbg = state;
    end

    // ---------------------------------------------------------------- datapath
    // Each counter only runs in its own state and is cleared everywhere else,
    // so every state starts counting from zero. All counters saturate.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_cnt    <= '0;
            t_cnt    <= '0;
            r_cnt    <= '0;
            s_cnt    <= '0;
            pend_idx <= MAP_IDX_NOM;
            map_idx  <= MAP_IDX_NOM;
            forced   <= 1'b0;
            por_q    <= 1'b1;
        end else begin
            por_q <= 1'b0;

            if (state != SYNC) begin
                q_cnt <= '0;
            end else if (m2) begin
                q_cnt <= '0;
            end else if (q_cnt != Q_LAST) begin
                q_cnt <= q_cnt + 1'b1;
            end

            if (state != SYNC) begin
                t_cnt <= '0;
            end else if (t_cnt != T_LAST) begin
                t_cnt <= t_cnt + 1'b1;
            end

            if (state != RESET) begin
                r_cnt <= '0;
            end else if (r_cnt != R_LAST) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (state != RELEASE) begin
                s_cnt <= '0;
            end else if (s_cnt != S_LAST) begin
                s_cnt <= s_cnt + 1'b1;
            end

            if (accept) begin
                pend_idx <= req_idx;
                forced   <= 1'b0;
            end

            // A quiet window found on the timeout cycle still counts as quiet.
            if (to_hit && !quiet_hit) begin
                forced <= 1'b1;
            end

            // Commit on the last reset cycle: the hub sees the new index only
            // while the mapper is still held in reset.
            if ((state == RESET) && (r_cnt == R_LAST)) begin
                map_idx <= pend_idx;
            end
        end
    end

endmodule

// File: tb/tb_map_sel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_map_sel_ctrl
// Self-checking bench for map_sel_ctrl. Inputs are driven and outputs sampled
// 1 time unit after each rising edge. A transaction's expected timeline is
// derived from the m2 trace: the sync phase ends on the first cycle that
// closes a run of QUIET_CYC lows, or on cycle QUIET_TO-1 (forced); the reset,
// release and done phases then follow with fixed lengths.
// -----------------------------------------------------------------------------
module tb_map_sel_ctrl;
    import map_sel_pkg::*;

    localparam int QUIET_CYC  = 8;
    localparam int QUIET_TO   = 4096;
    localparam int RST_CYC    = 16;
    localparam int SETTLE_CYC = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       m2;
    logic       req;
    logic [7:0] req_idx;
    logic [7:0] map_idx;
    logic       map_rst;
    logic       busy;
    logic       ack;
    logic       err;
    logic       forced;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] cur_idx    = 8'd0;
    logic       cur_forced = 1'b0;
    logic       m2_seq [QUIET_TO];

    typedef struct {
        logic [7:0] idx;
        int         pat;
        int         exp_ack;
        logic       exp_forced;
    } vec_t;

    vec_t tbl [5];

    map_sel_ctrl #(
        .QUIET_CYC  (QUIET_CYC),
        .QUIET_TO   (QUIET_TO),
        .RST_CYC    (RST_CYC),
        .SETTLE_CYC (SETTLE_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m2        (m2),
        .req       (req),
        .req_idx   (req_idx),
        .map_idx   (map_idx),
        .map_rst   (map_rst),
        .busy      (busy),
        .ack       (ack),
        .err       (err),
        .forced    (forced),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [12:0] act_vec();
        return {busy, map_rst, ack, forced, err, map_idx};
    endfunction

    function automatic logic [12:0] mk_vec(logic b, logic r, logic a, logic f, logic e, logic [7:0] i);
        return {b, r, a, f, e, i};
    endfunction

    function automatic logic supported(input logic [7:0] idx);
        case (idx)
            0, 15, 28, 40, 41, 42, 57, 58, 61, 91, 99, 101, 107, 112, 164, 168,
            178, 188, 193, 200, 201, 202, 203, 212, 227, 231, 234, 240, 241, 242,
            246: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Sync phase length from the m2 trace: k is the last sync cycle index.
    function automatic void model_sync(output int k, output logic f);
        int run;
        run = 0;
        k   = -1;
        f   = 1'b0;
        for (int j = 0; j < QUIET_TO; j++) begin
            run = m2_seq[j] ? 0 : run + 1;
            if (run >= QUIET_CYC) begin
                k = j;
                break;
            end
        end
        if (k < 0) begin
            k = QUIET_TO - 1;
            f = 1'b1;
        end
    endfunction

    // Expected outputs in cycle c of a transaction (c=0 is the request cycle).
    function automatic logic [12:0] exp_vec(int c, int k, logic f, logic [7:0] old_i, logic [7:0] new_i);
        if (c == 0)                            return mk_vec(0, 0, 0, cur_forced, 0, old_i);
        if (c <= k + 1)                        return mk_vec(1, 0, 0, 0, 0, old_i);
        if (c <= k + 1 + RST_CYC)              return mk_vec(1, 1, 0, f, 0, old_i);
        if (c <= k + 1 + RST_CYC + SETTLE_CYC) return mk_vec(1, 0, 0, f, 0, new_i);
        if (c == k + 2 + RST_CYC + SETTLE_CYC) return mk_vec(1, 0, 1, f, 0, new_i);
        return mk_vec(0, 0, 0, f, 0, new_i);
    endfunction

    task automatic run_txn(input logic [7:0] idx, input int pat, output int ack_at, output logic frc_at_ack);
        int   k;
        logic f;
        logic [7:0] old_i;
        for (int j = 0; j < QUIET_TO; j++) begin
            case (pat)
                0:       m2_seq[j] = 1'b0;
                1:       m2_seq[j] = ((j / 4) % 2) == 1;
                2:       m2_seq[j] = (j == 7);
                3:       m2_seq[j] = (j < 3);
                default: m2_seq[j] = ($urandom_range(0, 99) < 25);
            endcase
        end
        model_sync(k, f);
        old_i      = cur_idx;
        ack_at     = -1;
        frc_at_ack = 1'b0;
        for (int c = 0; c <= k + RST_CYC + SETTLE_CYC + 3; c++) begin
            if (c == 0) begin
                req     = 1'b1;
                req_idx = idx;
            end else if (c <= k + 2 + RST_CYC + SETTLE_CYC) begin
                // requests while busy must be ignored
                req     = 1'($urandom_range(0, 1));
                req_idx = 8'($urandom_range(0, 255));
            end else begin
                req = 1'b0;
            end
            m2 = (c >= 1 && c <= k + 1) ? m2_seq[c - 1] : 1'($urandom_range(0, 1));
            chk("cycle", 32'(act_vec()), 32'(exp_vec(c, k, f, old_i, idx)));
            if (ack && ack_at < 0) begin
                ack_at     = c;
                frc_at_ack = forced;
            end
            step();
        end
        req        = 1'b0;
        cur_idx    = idx;
        cur_forced = f;
    endtask

`ifdef MAP_IDX_CHECK_EN
    task automatic err_seq(input logic [7:0] idx);
        req     = 1'b1;
        req_idx = idx;
        m2      = 1'($urandom_range(0, 1));
        step();
        req = 1'b0;
        chk("err_pulse", 32'(act_vec()), 32'(mk_vec(0, 0, 0, cur_forced, 1, cur_idx)));
        chk("err_state", 32'(state_dbg), 32'(IDLE));
        step();
        chk("err_clear", 32'(act_vec()), 32'(mk_vec(0, 0, 0, cur_forced, 0, cur_idx)));
    endtask
`endif

    initial begin
        int   a;
        logic f;
        logic [7:0] idx;
        int   ack_seen;

`ifdef MAP_IDX_CHECK_EN
        tbl[0] = '{idx: 8'd42, pat: 0, exp_ack: 33, exp_forced: 1'b0};
`else
        tbl[0] = '{idx: 8'd4,  pat: 0, exp_ack: 33, exp_forced: 1'b0};
`endif
        tbl[1] = '{idx: 8'd91,  pat: 1, exp_ack: 4121, exp_forced: 1'b1};
        tbl[2] = '{idx: 8'd91,  pat: 0, exp_ack: 33,   exp_forced: 1'b0};
        tbl[3] = '{idx: 8'd200, pat: 2, exp_ack: 41,   exp_forced: 1'b0};
        tbl[4] = '{idx: 8'd15,  pat: 3, exp_ack: 36,   exp_forced: 1'b0};

        // ---- reset then idle
        rst = 1'b1; req = 1'b0; req_idx = 8'd0; m2 = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_outputs", 32'(act_vec()), 32'(mk_vec(0, 1, 0, 0, 0, 8'd0)));
        chk("rst_state", 32'(state_dbg), 32'(IDLE));
        step();
        chk("post_rst", 32'(act_vec()), 32'(mk_vec(0, 0, 0, 0, 0, 8'd0)));
        step();

        // ---- directed table
        for (int i = 0; i < 5; i++) begin
            run_txn(tbl[i].idx, tbl[i].pat, a, f);
            chk("ack_cycle", 32'(a), 32'(tbl[i].exp_ack));
            chk("forced_at_ack", 32'(f), 32'(tbl[i].exp_forced));
        end

`ifdef MAP_IDX_CHECK_EN
        err_seq(8'd5);
        run_txn(8'd246, 0, a, f);
        chk("ack_246", 32'(a), 32'd33);
`endif

        // ---- randomized transactions
        for (int i = 0; i < 24; i++) begin
            idx = 8'($urandom_range(0, 255));
`ifdef MAP_IDX_CHECK_EN
            if (!supported(idx)) begin
                err_seq(idx);
                continue;
            end
`endif
            run_txn(idx, 4, a, f);
        end

        // ---- reset in the middle of RESET discards the pending index
        req = 1'b1; req_idx = 8'd40; m2 = 1'b0;
        step();
        req = 1'b0;
        for (int c = 1; c < 12; c++) step();
        chk("mid_in_reset", 32'(map_rst), 32'd1);
        chk("mid_state", 32'(state_dbg), 32'(RESET));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_outputs", 32'(act_vec()), 32'(mk_vec(0, 1, 0, 0, 0, 8'd0)));
        chk("mid_rst_state", 32'(state_dbg), 32'(IDLE));
        cur_idx    = 8'd0;
        cur_forced = 1'b0;
        ack_seen   = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (ack || map_idx != 8'd0 || busy) ack_seen++;
        end
        chk("mid_no_ack", 32'(ack_seen), 32'd0);
        run_txn(8'd40, 0, a, f);
        chk("mid_retry_ack", 32'(a), 32'd33);
        chk("mid_retry_idx", 32'(map_idx), 32'd40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
